// File: rtl/slave_fsm_arbiter_pkg.sv
// Shared constants for the slave FSM arbiter: state encodings, time-out default, counter width.
// Pure declarations; no logic, no latency, no backpressure.
package slave_arb_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] START   = 2'b01;
  localparam logic [1:0] WAIT    = 2'b10;
  localparam logic [1:0] RECOVER = 2'b11;

  localparam int unsigned TIMEOUT_DEFAULT = 32'd50_000_000;
  localparam int          CNT_W           = 32;

endpackage

// File: rtl/slave_fsm_arbiter_rr_picker.sv
// Combinational rotate-priority picker: scans upward from last_owner+1 with wrap-around.
// Zero latency; no backpressure, it only reports which pending request wins.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    // Offsets 1..NUM_REQ so the previous owner is considered last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_owner) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/slave_fsm_arbiter.sv
// Round-robin share of one slave FSM: grant, start pulse, busy/done tracking, time-out; ack/err one cycle after completion/time-out.
// Backpressure: one transaction at a time; other requests wait in IDLE, and RECOVER holds off new grants until the slave drops busy.
module slave_fsm_arbiter
  import slave_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_PERIOD = TIMEOUT_DEFAULT,
  parameter int          IDX_W          = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic [IDX_W-1:0]   owner,
  output logic               busy,
  output logic [1:0]         state,
  output logic               slave_start,
  input  logic               slave_busy,
  input  logic               slave_done
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_PERIOD - 1);

  logic [1:0]         next_state;
  logic [IDX_W-1:0]   last_owner;
  logic [CNT_W-1:0]   cnt;
  logic               seen_busy;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic               complete;
  logic               timeout;
  logic [NUM_REQ-1:0] owner_oh;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req         (req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A done seen before busy is leftover from the previous job and must not complete this one.
  assign complete = (state == WAIT) && seen_busy && !slave_busy && slave_done;
  assign timeout  = (state == WAIT) && (cnt == TO_LAST) && !complete;
  assign owner_oh = NUM_REQ'(1) << owner;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_valid) next_state = START;
      START:   next_state = WAIT;
      WAIT: begin
        if (complete)     next_state = IDLE;
        else if (timeout) next_state = RECOVER;
      end
      RECOVER: if (!slave_busy) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    slave_start = (state == START);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      cnt        <= '0;
      seen_busy  <= 1'b0;
      ack        <= '0;
      err        <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_idx;
            last_owner <= grant_idx;
          end
        end
        START: begin
          cnt       <= '0;
          seen_busy <= 1'b0;
        end
        WAIT: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          if (slave_busy) seen_busy <= 1'b1;
          if (complete)     ack <= owner_oh;
          else if (timeout) err <= owner_oh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_fsm_arbiter.sv
// Directed bench for slave_fsm_arbiter with a scripted slave model and a queue-based scoreboard.
module tb_slave_fsm_arbiter;
  import slave_arb_pkg::*;

  localparam int N  = 4;
  localparam int TP = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] ack, err;
  logic [1:0]   owner;
  logic         busy;
  logic [1:0]   state;
  logic         slave_start;
  logic         slave_busy = 1'b0;
  logic         slave_done = 1'b1;

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] e;
    int           d;
  } resp_t;

  resp_t exp_resp[$];
  int    exp_grant[$];

  int job_s = 0, job_b = 3, sl_t = 0;
  bit sl_act = 1'b0;

  slave_fsm_arbiter #(.NUM_REQ(N), .TIMEOUT_PERIOD(TP)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .err         (err),
    .owner       (owner),
    .busy        (busy),
    .state       (state),
    .slave_start (slave_start),
    .slave_busy  (slave_busy),
    .slave_done  (slave_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_job(input int idx, input int d, input bit is_err);
    resp_t        e;
    logic [N-1:0] oh;
    oh  = N'(1) << idx;
    e.a = is_err ? '0 : oh;
    e.e = is_err ? oh : '0;
    e.d = d;
    exp_grant.push_back(idx);
    exp_resp.push_back(e);
  endtask

  // Slave: after the start pulse, job_s cycles of stale done, then job_b cycles busy, then idle.
  always @(negedge clk) begin
    if (slave_start) begin
      sl_act = 1'b1; sl_t = 0; slave_busy = 1'b0; slave_done = 1'b1;
    end else if (sl_act) begin
      sl_t++;
      if (sl_t <= job_s) begin
        slave_busy = 1'b0; slave_done = 1'b1;
      end else if (sl_t <= job_s + job_b) begin
        slave_busy = 1'b1; slave_done = 1'b0;
      end else begin
        slave_busy = 1'b0; slave_done = 1'b1; sl_act = 1'b0;
      end
    end
  end

  resp_t r;
  int    g;
  always @(negedge clk) begin
    if (!rst) begin
      if (slave_start) begin
        start_cyc = cyc;
        if (exp_grant.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_grant: got owner %0d expected no grant", owner);
        end else begin
          g = exp_grant.pop_front();
          check("grant_owner", 32'(owner), 32'(g));
        end
      end
      if ((ack != '0) || (err != '0)) begin
        if (exp_resp.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got ack %b err %b expected none", ack, err);
        end else begin
          r = exp_resp.pop_front();
          check("resp_ack", 32'(ack), 32'(r.a));
          check("resp_err", 32'(err), 32'(r.e));
          check("resp_delay", 32'(cyc - start_cyc), 32'(r.d));
        end
      end
    end
  end

  // Wait for n ack/err pulses; hold=1 keeps all requests up until the last one.
  task automatic run_until(input int n, input bit hold);
    int got = 0;
    int t   = 0;
    while (got < n && t < 400) begin
      @(negedge clk);
      t++;
      if ((ack != '0) || (err != '0)) begin
        got++;
        if (!hold) req = req & ~(ack | err);
        else if (got == n) req = '0;
      end
    end
    if (got < n) begin
      tests++; fails++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", got, n);
      req = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'(IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_start"}, 32'(slave_start), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Fairness: all four request from reset, expected grant order 0,1,2,3,0.
    job_s = 0; job_b = 3;
    for (int i = 0; i < 5; i++) expect_job(i % N, 5, 1'b0);
    req = 4'b1111;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    run_until(5, 1'b1);

    // Single request from requester 2, slave busy for 5 cycles.
    repeat (2) @(negedge clk);
    job_b = 5; expect_job(2, 7, 1'b0);
    req = 4'b0100;
    run_until(1, 1'b0);
    @(negedge clk);
    check("single_busy_after", 32'(busy), 32'd0);

    // Time-out with busy stuck for 20 cycles: err TP cycles after WAIT entry, then RECOVER.
    job_b = 20; expect_job(0, TP + 1, 1'b1);
    req = 4'b0001;
    run_until(1, 1'b0);
    repeat (10) @(negedge clk);
    check("recover_hold_state", 32'(state), 32'(RECOVER));
    check("recover_hold_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("recover_exit_state", 32'(state), 32'(IDLE));
    check("recover_exit_busy", 32'(busy), 32'd0);

    // Stale done for 3 cycles before busy.
    job_s = 3; job_b = 4; expect_job(3, 9, 1'b0);
    req = 4'b1000;
    run_until(1, 1'b0);

    // Completion lands on the same cycle as the time-out count.
    job_s = 0; job_b = 9; expect_job(1, TP + 1, 1'b0);
    req = 4'b0010;
    run_until(1, 1'b0);

    // Reset during WAIT drops the in-flight response and restores priority to requester 0.
    repeat (2) @(negedge clk);
    job_b = 8; exp_grant.push_back(1);
    req = 4'b0010;
    t = 0;
    while (!slave_start && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("midwait_grant_seen", 32'(slave_start), 32'd1);
    repeat (3) @(negedge clk);
    check("midwait_state", 32'(state), 32'(WAIT));
    rst = 1'b1; req = '0;
    sl_act = 1'b0; slave_busy = 1'b0; slave_done = 1'b1;
    @(negedge clk);
    check_reset_outputs("midwait_rst");
    rst = 1'b0;
    job_b = 3;
    expect_job(0, 5, 1'b0);
    expect_job(1, 5, 1'b0);
    req = 4'b0011;
    run_until(2, 1'b0);

    repeat (5) @(negedge clk);
    check("leftover_grants", 32'(exp_grant.size()), 32'd0);
    check("leftover_resps", 32'(exp_resp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
